// File: rtl/decoder_2ri14_pipe.sv
// Registered multi-lane decode stage for 2RI14 instructions (LL.W, SC.W, CSRRD/CSRWR/CSRXCHG).
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.
module decoder_2ri14_pipe #(
    parameter int LANES = 2,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [LANES-1:0]      in_valid,
    input  logic [32*LANES-1:0]   in_pc,
    input  logic [32*LANES-1:0]   in_inst,
    output logic                  in_ready,
    output logic [CW-1:0]         in_consumed,
    output logic [LANES-1:0]      out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_pc,
    output logic [32*LANES-1:0]   out_inst,
    output logic [LANES-1:0]      out_reg_write_en,
    output logic [LANES-1:0]      out_reg1_read_en,
    output logic [LANES-1:0]      out_reg2_read_en,
    output logic [5*LANES-1:0]    out_reg1_addr,
    output logic [5*LANES-1:0]    out_reg2_addr,
    output logic [5*LANES-1:0]    out_reg_write_addr,
    output logic [8*LANES-1:0]    out_aluop,
    output logic [3*LANES-1:0]    out_alusel,
    output logic [32*LANES-1:0]   out_imm,
    output logic [LANES-1:0]      out_csr_read_en,
    output logic [LANES-1:0]      out_csr_write_en,
    output logic [LANES-1:0]      out_is_privilege,
    output logic [LANES-1:0]      out_inst_valid,
    output logic [LANES-1:0]      out_is_exception,
    output logic [14*LANES-1:0]   out_csr_addr,
    output logic [7*LANES-1:0]    out_exception_cause,
    input  logic                  csr_commit
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_decoded,
    output logic [31:0]           perf_csr_stall
`endif
);

    localparam logic [7:0]  LLW_OPCODE         = 8'h20;
    localparam logic [7:0]  SCW_OPCODE         = 8'h21;
    localparam logic [7:0]  CSR_OPCODE         = 8'h04;
    localparam logic [13:0] CSR_LLBCTL         = 14'h060;
    localparam logic [7:0]  ALU_NOP            = 8'h00;
    localparam logic [7:0]  ALU_LLW            = 8'h70;
    localparam logic [7:0]  ALU_SCW            = 8'h71;
    localparam logic [7:0]  ALU_CSRRD          = 8'h72;
    localparam logic [7:0]  ALU_CSRWR          = 8'h73;
    localparam logic [7:0]  ALU_CSRXCHG        = 8'h74;
    localparam logic [2:0]  ALU_SEL_NOP        = 3'd0;
    localparam logic [2:0]  ALU_SEL_CSR        = 3'd6;
    localparam logic [2:0]  ALU_SEL_LOAD_STORE = 3'd7;
    localparam logic [6:0]  EXCEPTION_INE      = 7'h0d;

    localparam logic [0:0]  ST_RUN      = 1'b0;
    localparam logic [0:0]  ST_CSR_WAIT = 1'b1;

    typedef struct packed {
        logic        reg_we;
        logic        r1_en;
        logic        r2_en;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wa;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] imm;
        logic        csr_re;
        logic        csr_we;
        logic        priv;
        logic        iv;
        logic        exc;
        logic [13:0] csr_addr;
        logic [6:0]  cause;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t        d;
        logic [4:0]  rj;
        logic [4:0]  rd;
        logic [13:0] si14;
        rj   = inst[9:5];
        rd   = inst[4:0];
        si14 = inst[23:10];
        d    = '0;
        case (inst[31:24])
            LLW_OPCODE, SCW_OPCODE: begin
                d.reg_we   = 1'b1;
                d.wa       = rd;
                d.r1_en    = 1'b1;
                d.r1       = rj;
                d.csr_re   = 1'b1;
                d.csr_addr = CSR_LLBCTL;
                d.imm      = {{16{si14[13]}}, si14, 2'b00};
                d.alusel   = ALU_SEL_LOAD_STORE;
                d.iv       = 1'b1;
                if (inst[31:24] == SCW_OPCODE) begin
                    d.r2_en = 1'b1;
                    d.r2    = rd;
                    d.aluop = ALU_SCW;
                end else begin
                    d.aluop = ALU_LLW;
                end
            end
            CSR_OPCODE: begin
                d.priv     = 1'b1;
                d.csr_addr = si14;
                d.reg_we   = 1'b1;
                d.wa       = rd;
                d.csr_re   = 1'b1;
                d.alusel   = ALU_SEL_CSR;
                d.iv       = 1'b1;
                // rj selects the flavour: 0 = read, 1 = write, else exchange under mask rj
                if (rj == 5'd0) begin
                    d.aluop = ALU_CSRRD;
                end else if (rj == 5'd1) begin
                    d.r1_en  = 1'b1;
                    d.r1     = rd;
                    d.csr_we = 1'b1;
                    d.aluop  = ALU_CSRWR;
                end else begin
                    d.r1_en  = 1'b1;
                    d.r1     = rd;
                    d.r2_en  = 1'b1;
                    d.r2     = rj;
                    d.csr_we = 1'b1;
                    d.aluop  = ALU_CSRXCHG;
                end
            end
            default: begin
                d.exc    = 1'b1;
                d.cause  = EXCEPTION_INE;
                d.aluop  = ALU_NOP;
                d.alusel = ALU_SEL_NOP;
            end
        endcase
        return d;
    endfunction

    dec_t           dec   [LANES];
    dec_t           dec_q [LANES];
    logic [LANES-1:0] take;
    logic [CW-1:0]  consumed;
    logic           cut;
    logic [0:0]     state;
    logic           accept;

    // Lanes are taken oldest-first; the first CSR write closes the bundle.
    always_comb begin
        take     = '0;
        consumed = '0;
        cut      = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            dec[i] = decode(in_inst[i*32 +: 32]);
            if (!cut && in_valid[i]) begin
                take[i]  = 1'b1;
                consumed = consumed + CW'(1);
                if (dec[i].csr_we) cut = 1'b1;
            end
        end
    end

    assign in_ready    = rst_n && (state == ST_RUN) && ((out_valid == '0) || out_ready) && !flush;
    assign accept      = in_ready && in_valid[0];
    assign in_consumed = consumed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (flush) begin
            state <= ST_RUN;
        end else if (accept && cut) begin
            state <= ST_CSR_WAIT;
        end else if (state == ST_CSR_WAIT && csr_commit) begin
            state <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
        end else if (flush) begin
            out_valid <= '0;
        end else if (accept) begin
            out_valid <= take;
        end else if (out_ready) begin
            out_valid <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc   <= '0;
            out_inst <= '0;
            for (int i = 0; i < LANES; i++) dec_q[i] <= '0;
        end else if (accept && !flush) begin
            out_pc   <= in_pc;
            out_inst <= in_inst;
            for (int i = 0; i < LANES; i++) dec_q[i] <= dec[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign out_reg_write_en[g]             = dec_q[g].reg_we;
        assign out_reg1_read_en[g]             = dec_q[g].r1_en;
        assign out_reg2_read_en[g]             = dec_q[g].r2_en;
        assign out_reg1_addr[g*5 +: 5]         = dec_q[g].r1;
        assign out_reg2_addr[g*5 +: 5]         = dec_q[g].r2;
        assign out_reg_write_addr[g*5 +: 5]    = dec_q[g].wa;
        assign out_aluop[g*8 +: 8]             = dec_q[g].aluop;
        assign out_alusel[g*3 +: 3]            = dec_q[g].alusel;
        assign out_imm[g*32 +: 32]             = dec_q[g].imm;
        assign out_csr_read_en[g]              = dec_q[g].csr_re;
        assign out_csr_write_en[g]             = dec_q[g].csr_we;
        assign out_is_privilege[g]             = dec_q[g].priv;
        assign out_inst_valid[g]               = dec_q[g].iv;
        assign out_is_exception[g]             = dec_q[g].exc;
        assign out_csr_addr[g*14 +: 14]        = dec_q[g].csr_addr;
        assign out_exception_cause[g*7 +: 7]   = dec_q[g].cause;
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded   <= '0;
            perf_csr_stall <= '0;
        end else begin
            if (accept) perf_decoded <= perf_decoded + 32'(consumed);
            if (state == ST_CSR_WAIT && in_valid[0]) perf_csr_stall <= perf_csr_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_2ri14_pipe.sv
// Directed bench for decoder_2ri14_pipe with a one-deep expected-bundle queue.
// Perf counter checks are built when DECODE_PERF_CNT_EN is defined.
module tb_decoder_2ri14_pipe;

    localparam int LANES = 2;
    localparam int CW    = 2;
    localparam int LW    = 151;
    localparam int BW    = 2 + 2*LW;

    localparam logic [13:0] LLBCTL  = 14'h060;
    localparam logic [6:0]  EXC_INE = 7'h0d;

    localparam logic [31:0] I_LLW    = 32'h20FFFCC5;
    localparam logic [31:0] I_LLW2   = 32'h20000822;
    localparam logic [31:0] I_SCW    = 32'h21001467;
    localparam logic [31:0] I_CSRWR  = 32'h04000424;
    localparam logic [31:0] I_CSRRD  = 32'h04000404;
    localparam logic [31:0] I_CSRX   = 32'h040008A9;
    localparam logic [31:0] I_BAD    = 32'hFF000000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic [LANES-1:0]      in_valid;
    logic [32*LANES-1:0]   in_pc;
    logic [32*LANES-1:0]   in_inst;
    logic                  in_ready;
    logic [CW-1:0]         in_consumed;
    logic [LANES-1:0]      out_valid;
    logic                  out_ready;
    logic [32*LANES-1:0]   out_pc, out_inst, out_imm;
    logic [LANES-1:0]      out_reg_write_en, out_reg1_read_en, out_reg2_read_en;
    logic [5*LANES-1:0]    out_reg1_addr, out_reg2_addr, out_reg_write_addr;
    logic [8*LANES-1:0]    out_aluop;
    logic [3*LANES-1:0]    out_alusel;
    logic [LANES-1:0]      out_csr_read_en, out_csr_write_en, out_is_privilege;
    logic [LANES-1:0]      out_inst_valid, out_is_exception;
    logic [14*LANES-1:0]   out_csr_addr;
    logic [7*LANES-1:0]    out_exception_cause;
    logic                  csr_commit;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0]           perf_decoded, perf_csr_stall;
`endif

    logic [BW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    decoder_2ri14_pipe #(.LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_ready(in_ready), .in_consumed(in_consumed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_reg_write_en(out_reg_write_en), .out_reg1_read_en(out_reg1_read_en),
        .out_reg2_read_en(out_reg2_read_en),
        .out_reg1_addr(out_reg1_addr), .out_reg2_addr(out_reg2_addr),
        .out_reg_write_addr(out_reg_write_addr),
        .out_aluop(out_aluop), .out_alusel(out_alusel), .out_imm(out_imm),
        .out_csr_read_en(out_csr_read_en), .out_csr_write_en(out_csr_write_en),
        .out_is_privilege(out_is_privilege), .out_inst_valid(out_inst_valid),
        .out_is_exception(out_is_exception), .out_csr_addr(out_csr_addr),
        .out_exception_cause(out_exception_cause),
        .csr_commit(csr_commit)
`ifdef DECODE_PERF_CNT_EN
        ,
        .perf_decoded(perf_decoded), .perf_csr_stall(perf_csr_stall)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode of one lane, written field by field from the instruction format.
    function automatic logic [LW-1:0] model_lane(input logic [31:0] pc, input logic [31:0] inst);
        logic        we, r1e, r2e, cre, cwe, pv, iv, ex;
        logic [4:0]  r1, r2, wa, rj, rd;
        logic [7:0]  aop;
        logic [2:0]  asel;
        logic [31:0] imm;
        logic [13:0] ca, si;
        logic [6:0]  cause;
        {we, r1e, r2e, cre, cwe, pv, iv, ex} = '0;
        {r1, r2, wa, aop, asel, imm, ca, cause} = '0;
        rj = inst[9:5];
        rd = inst[4:0];
        si = inst[23:10];
        case (inst[31:24])
            8'h20: begin
                we = 1; wa = rd; r1e = 1; r1 = rj; cre = 1; ca = LLBCTL;
                imm = {{16{si[13]}}, si, 2'b00}; aop = 8'h70; asel = 3'd7; iv = 1;
            end
            8'h21: begin
                we = 1; wa = rd; r1e = 1; r1 = rj; r2e = 1; r2 = rd; cre = 1; ca = LLBCTL;
                imm = {{16{si[13]}}, si, 2'b00}; aop = 8'h71; asel = 3'd7; iv = 1;
            end
            8'h04: begin
                pv = 1; ca = si; we = 1; wa = rd; cre = 1; asel = 3'd6; iv = 1;
                if (rj == 0) aop = 8'h72;
                else if (rj == 1) begin r1e = 1; r1 = rd; cwe = 1; aop = 8'h73; end
                else begin r1e = 1; r1 = rd; r2e = 1; r2 = rj; cwe = 1; aop = 8'h74; end
            end
            default: begin ex = 1; cause = EXC_INE; end
        endcase
        return {pc, inst, we, r1e, r2e, r1, r2, wa, aop, asel, imm, cre, cwe, pv, iv, ex, ca, cause};
    endfunction

    function automatic logic [BW-1:0] model_bundle(input logic [1:0] v, input int cons,
                                                   input logic [63:0] pcs, input logic [63:0] insts);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i] && i < cons) begin
                b[2*LW + i] = 1'b1;
                b[i*LW +: LW] = model_lane(pcs[i*32 +: 32], insts[i*32 +: 32]);
            end
        end
        return b;
    endfunction

    function automatic logic [LW-1:0] obs_lane(input int i);
        return {out_pc[i*32 +: 32], out_inst[i*32 +: 32], out_reg_write_en[i], out_reg1_read_en[i],
                out_reg2_read_en[i], out_reg1_addr[i*5 +: 5], out_reg2_addr[i*5 +: 5],
                out_reg_write_addr[i*5 +: 5], out_aluop[i*8 +: 8], out_alusel[i*3 +: 3],
                out_imm[i*32 +: 32], out_csr_read_en[i], out_csr_write_en[i], out_is_privilege[i],
                out_inst_valid[i], out_is_exception[i], out_csr_addr[i*14 +: 14],
                out_exception_cause[i*7 +: 7]};
    endfunction

    function automatic logic [BW-1:0] observe();
        logic [BW-1:0] o;
        o = '0;
        for (int i = 0; i < LANES; i++) begin
            o[2*LW + i] = out_valid[i];
            if (out_valid[i]) o[i*LW +: LW] = obs_lane(i);
        end
        return o;
    endfunction

    // driver: one cycle; compares the presented bundle, drives, checks handshake, updates scoreboard
    task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic ordy, input logic fl, input logic cm,
                        input logic exp_rdy, input int exp_cons);
        logic [BW-1:0] e;
        logic [31:0]   pc0;
        @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("bundle", observe(), e);
        pc0        = 32'($urandom_range(0, 16'hFFFF)) << 2;
        in_valid   = v;
        in_inst    = {i1, i0};
        in_pc      = {pc0 + 32'd4, pc0};
        out_ready  = ordy;
        flush      = fl;
        csr_commit = cm;
        #1;
        chk("in_ready", BW'(in_ready), BW'(exp_rdy));
        if (exp_rdy && v[0]) chk("in_consumed", BW'(in_consumed), BW'(exp_cons));
        if (exp_q.size() != 0 && (ordy || fl)) void'(exp_q.pop_front());
        if (exp_rdy && v[0]) exp_q.push_back(model_bundle(v, exp_cons, in_pc, in_inst));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_pc = '0; in_inst = '0;
        out_ready = 1'b0; csr_commit = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", BW'(in_ready), BW'(1'b0));
        chk("reset_out_valid", BW'(out_valid), BW'(2'b00));
        chk("reset_imm", BW'(out_imm), BW'(64'h0));
        rst_n = 1'b1;

        step(2'b00, 0, 0, 1, 0, 0, 1, 0);
        step(2'b01, I_LLW, 0, 1, 0, 0, 1, 1);
        step(2'b00, 0, 0, 1, 0, 0, 1, 0);
        chk("llw_valid", BW'(out_valid), BW'(2'b01));
        chk("llw_imm", BW'(out_imm[31:0]), BW'(32'hFFFFFFFC));
        chk("llw_reg1", BW'(out_reg1_addr[4:0]), BW'(5'd6));
        chk("llw_wa", BW'(out_reg_write_addr[4:0]), BW'(5'd5));
        chk("llw_csr_addr", BW'(out_csr_addr[13:0]), BW'(LLBCTL));
        chk("llw_csr_re", BW'(out_csr_read_en[0]), BW'(1'b1));

        // back-to-back full bundles, then an illegal opcode in lane 0
        step(2'b11, I_LLW, I_SCW, 1, 0, 0, 1, 2);
        step(2'b11, I_BAD, I_LLW2, 1, 0, 0, 1, 2);
        step(2'b11, I_CSRWR, I_CSRRD, 1, 0, 0, 1, 1);
        chk("bad_inst_valid", BW'(out_inst_valid[0]), BW'(1'b0));
        chk("bad_exc", BW'(out_is_exception[0]), BW'(1'b1));
        chk("bad_cause", BW'(out_exception_cause[6:0]), BW'(EXC_INE));
        chk("bad_reg_we", BW'(out_reg_write_en[0]), BW'(1'b0));

        // CSR write serialisation
        step(2'b11, I_CSRRD, I_LLW2, 1, 0, 0, 0, 0);
        chk("csrwr_we", BW'(out_csr_write_en[0]), BW'(1'b1));
        chk("csrwr_reg1", BW'(out_reg1_addr[4:0]), BW'(5'd4));
        chk("csrwr_valid", BW'(out_valid), BW'(2'b01));
        step(2'b11, I_CSRRD, I_LLW2, 1, 0, 0, 0, 0);
        step(2'b11, I_CSRRD, I_LLW2, 1, 0, 1, 0, 0);
        step(2'b11, I_CSRRD, I_LLW2, 1, 0, 0, 1, 2);

        // backpressure: three held cycles, then retire and accept together
        step(2'b01, I_LLW, 0, 0, 0, 0, 0, 0);
        chk("csrrd_re", BW'(out_csr_read_en[0]), BW'(1'b1));
        chk("csrrd_we", BW'(out_csr_write_en[0]), BW'(1'b0));
        step(2'b01, I_LLW, 0, 0, 0, 0, 0, 0);
        step(2'b01, I_LLW, 0, 0, 0, 0, 0, 0);
        step(2'b01, I_SCW, 0, 1, 0, 0, 1, 1);

        // flush together with csr_commit while waiting
        step(2'b11, I_CSRX, I_LLW, 1, 0, 0, 1, 1);
        step(2'b00, 0, 0, 0, 1, 1, 0, 0);
        step(2'b01, I_LLW, 0, 1, 0, 0, 1, 1);
        // csr_commit in RUN has no effect
        step(2'b01, I_SCW, 0, 1, 0, 1, 1, 1);
        step(2'b00, 0, 0, 1, 0, 0, 1, 0);

        // asynchronous reset in the middle of a bundle
        step(2'b11, I_LLW, I_SCW, 1, 0, 0, 1, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = '0;
        #1;
        chk("async_rst_valid", BW'(out_valid), BW'(2'b00));
        chk("async_rst_ready", BW'(in_ready), BW'(1'b0));
        chk("async_rst_pc", BW'(out_pc), BW'(64'h0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b00, 0, 0, 1, 0, 0, 1, 0);

`ifdef DECODE_PERF_CNT_EN
        step(2'b11, I_LLW, I_SCW, 1, 0, 0, 1, 2);
        step(2'b11, I_LLW, I_CSRWR, 1, 0, 0, 1, 2);
        for (int k = 0; k < 4; k++) step(2'b01, I_LLW, 0, 1, 0, 0, 0, 0);
        step(2'b00, 0, 0, 1, 0, 1, 0, 0);
        chk("perf_decoded", BW'(perf_decoded), BW'(32'd4));
        chk("perf_csr_stall", BW'(perf_csr_stall), BW'(32'd4));
`endif

        step(2'b00, 0, 0, 1, 0, 0, 1, 0);
        step(2'b00, 0, 0, 1, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_2ri14_pipe.md
Name: decoder_2ri14_pipe

Overview:
Registered, multi-lane decode stage for the 2RI14 instruction class: LL.W, SC.W, CSRRD, CSRWR and CSRXCHG. It sits between the fetch buffer and dispatch, decoding up to LANES instructions per cycle behind a valid/ready handshake. CSR writes are serialised: every instruction after a CSR write is held until the backend commits that write.

Parameters:
LANES, 2, number of decode lanes (1..4); lane 0 is the oldest.
CW, $clog2(LANES+1), width of in_consumed.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; synchronous effect
in_valid  in  LANES  per-lane instruction valid; contiguous from lane 0
in_pc  in  32*LANES  per-lane PC
in_inst  in  32*LANES  per-lane instruction word
in_ready  out  1  stage accepts a bundle this cycle
in_consumed  out  CW  number of lanes taken on accept (lanes 0..in_consumed-1)
out_valid  out  LANES  per-lane decoded result valid
out_ready  in  1  dispatch accepts the whole output bundle
out_pc, out_inst  out  32*LANES  pass-through
out_reg_write_en, out_reg1_read_en, out_reg2_read_en  out  LANES each
out_reg1_addr, out_reg2_addr, out_reg_write_addr  out  5*LANES each
out_aluop  out  8*LANES;  out_alusel  out  3*LANES;  out_imm  out  32*LANES
out_csr_read_en, out_csr_write_en, out_is_privilege, out_inst_valid, out_is_exception  out  LANES each
out_csr_addr  out  14*LANES;  out_exception_cause  out  7*LANES
csr_commit  in  1  single-cycle pulse: the outstanding CSR write has retired

Behaviour:
Decode, per lane, combinational before the output register. Fields are rj=inst[9:5], rd=inst[4:0], si14=inst[23:10]; opcode is inst[31:24].
- LL.W (`LLW_OPCODE`)
  - rd written; reg1 = rj.
  - csr read of `CSR_LLBCTL`.
  - imm = sign_ext(si14)<<2.
  - aluop `ALU_LLW`, alusel `ALU_SEL_LOAD_STORE`.
- SC.W (`SCW_OPCODE`)
  - rd written; reg1 = rj, reg2 = rd.
  - csr read of LLBCTL.
  - imm = sign_ext(si14)<<2.
  - aluop `ALU_SCW`.
- CSR (`CSR_OPCODE`)
  - is_privilege = 1; csr_addr = si14; imm = 0; rd always written.
  - rj==0 (CSRRD): no GPR reads; csr read only.
  - rj==1 (CSRWR): reg1 = rd; csr read+write.
  - otherwise (CSRXCHG): reg1 = rd, reg2 = rj; csr read+write.
- Any other opcode
  - inst_valid = 0, is_exception = 1, cause `EXCEPTION_INE`.
  - All enables 0, aluop `ALU_NOP`, alusel `ALU_SEL_NOP`.
- Unused read addresses are 0.

Lane cut:
- k = lowest valid lane whose decode has csr_write_en = 1.
- If k exists, only lanes 0..k are accepted and in_consumed = k+1.
- Otherwise all valid lanes are accepted and in_consumed = popcount(in_valid).

FSM has two states: RUN and CSR_WAIT.
- in_ready = (state==RUN) && (out_valid==0 || out_ready) && !flush.
- Accept = in_ready && in_valid[0]. On accept, the output register loads the accepted lanes and out_valid is set for them only; other lanes get out_valid = 0.
- RUN -> CSR_WAIT on an accept that contains a CSR write.
- CSR_WAIT -> RUN on csr_commit. in_ready is 0 throughout CSR_WAIT; out_valid still drains normally.
- csr_commit arriving in RUN is ignored.
- If out_ready = 0 and out_valid != 0, all outputs hold stable.
- If out_ready = 1 and there is no accept, out_valid clears next cycle.
- Latency: accept in cycle N gives out_valid in cycle N+1. Throughput: one bundle per cycle.

Flush:
- Next edge: out_valid = 0, state = RUN.
- Flush has priority over accept and over csr_commit in the same cycle.

Reset (async, rst_n low):
- state = RUN, out_valid = 0, every registered output field = 0.
- in_ready is 0 while rst_n is low.

Optional Feature:
DECODE_PERF_CNT_EN
- Defined: adds two outputs, each reset to 0 and wrapping at 2^32.
  - perf_decoded[31:0]: increments by in_consumed on every accept.
  - perf_csr_stall[31:0]: increments by 1 on every cycle spent in CSR_WAIT with in_valid[0] = 1.
- Undefined: those ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- LANES=2, lane0 = 0x20FFFCC5 (LL.W rd=5, rj=6, si14=-1), out_ready=1 -> next cycle out_valid=01, imm=0xFFFFFFFC, reg1_addr=6, write_addr=5, csr_addr=LLBCTL, csr_read_en=1.
- lane0 = 0x04000424 (CSRWR csr=1, rd=4), lane1 = 0x04000404 (CSRRD) -> in_consumed=1, lane0 csr_write_en=1, reg1_addr=4; in_ready=0 until csr_commit. Lane1 is then accepted and decodes with csr_read_en=1, csr_write_en=0.
- lane0 = 0xFF000000 -> out_inst_valid=0, is_exception=1, cause=`EXCEPTION_INE`, reg_write_en=0.
- out_ready held 0 for 3 cycles with a bundle registered -> in_ready=0 and outputs unchanged. out_ready=1 -> bundle retires; a new bundle is accepted in the same cycle.
- In CSR_WAIT, assert flush and csr_commit together -> state=RUN, out_valid=0 next cycle. Separately, drop rst_n mid-bundle -> out_valid=0 immediately.
- With DECODE_PERF_CNT_EN: 2 full bundles then 4 stalled cycles in CSR_WAIT -> perf_decoded=4, perf_csr_stall=4.
